// File: rtl/axis_splitter_buf.sv
// axis_splitter_buf: buffered AXI4-Stream broadcast splitter.
// Each accepted slave beat is sliced into C_NUM_MI_SLOTS fields. Each field,
// together with tlast, goes into its own small FIFO. Every master port drains
// its FIFO independently, so a slow lane stalls the source only once its own
// FIFO is full.
// Optional feature macro: AXIS_SPLITTER_BUF_MASK_EN adds s_axis_tmask, which
// picks the destination slots of each beat. Without the macro, every beat is
// broadcast to all slots.
module axis_splitter_buf #(
    parameter int                            C_NUM_MI_SLOTS       = 3,
    parameter int                            C_S_AXIS_TDATA_WIDTH = 240,
    parameter int                            C_M_AXIS_TDATA_WIDTH = 72,
    parameter logic [32*C_NUM_MI_SLOTS-1:0]  C_M_AXIS_TDATA_LSB   = {32'd168, 32'd96, 32'd0},
    parameter int                            C_FIFO_DEPTH         = 4
) (
    input  logic                                           aclk,
    input  logic                                           aresetn,
    input  logic                                           s_axis_tvalid,
    output logic                                           s_axis_tready,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]                s_axis_tdata,
    input  logic                                           s_axis_tlast,
`ifdef AXIS_SPLITTER_BUF_MASK_EN
    input  logic [C_NUM_MI_SLOTS-1:0]                      s_axis_tmask,
`endif
    output logic [C_NUM_MI_SLOTS-1:0]                      m_axis_tvalid,
    input  logic [C_NUM_MI_SLOTS-1:0]                      m_axis_tready,
    output logic [C_NUM_MI_SLOTS*C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [C_NUM_MI_SLOTS-1:0]                      m_axis_tlast
);

    localparam int W     = C_M_AXIS_TDATA_WIDTH;
    localparam int PTR_W = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Reject unusable configurations at elaboration time.
    if (C_NUM_MI_SLOTS < 1 || C_NUM_MI_SLOTS > 16) begin : g_bad_slots
        $error("axis_splitter_buf: C_NUM_MI_SLOTS must be 1..16");
    end
    if (C_FIFO_DEPTH < 2 || (C_FIFO_DEPTH & (C_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axis_splitter_buf: C_FIFO_DEPTH must be a power of two >= 2");
    end

    logic                      rst_done_reg;
    logic [C_NUM_MI_SLOTS-1:0] sel;
    logic [C_NUM_MI_SLOTS-1:0] full;
    logic                      accept;
    logic                      unused_tdata;

    // Keeps lint quiet about slave data bits that no slot slices out.
    assign unused_tdata = ^s_axis_tdata;

`ifdef AXIS_SPLITTER_BUF_MASK_EN
    assign sel = s_axis_tmask;
`else
    assign sel = {C_NUM_MI_SLOTS{1'b1}};
`endif

    // Readiness uses only registered FIFO state, so m_axis_tready has no
    // combinational path to s_axis_tready. A full FIFO therefore blocks even
    // when it is being popped in the same cycle.
    assign s_axis_tready = rst_done_reg & ~|(sel & full);
    assign accept        = s_axis_tvalid & s_axis_tready;

    // Hold the slave side off until the first edge after reset is released.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_done_reg <= 1'b0;
        else          rst_done_reg <= 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_MI_SLOTS; gi++) begin : g_slot
            localparam int LSB = int'(C_M_AXIS_TDATA_LSB[32*gi +: 32]);

            if (LSB + W > C_S_AXIS_TDATA_WIDTH) begin : g_bad_lsb
                $error("axis_splitter_buf: slot slice exceeds slave TDATA width");
            end

            logic [W:0]       mem [C_FIFO_DEPTH];
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [CNT_W-1:0] count_reg;
            logic [CNT_W-1:0] count_next;
            logic             empty;
            logic             push;
            logic             pop;

            assign empty     = (count_reg == '0);
            assign full[gi]  = (count_reg == CNT_W'(C_FIFO_DEPTH));
            assign push      = accept & sel[gi];
            assign pop       = ~empty & m_axis_tready[gi];

            // Occupancy: push and pop in the same cycle cancel out.
            always_comb begin
                count_next = count_reg;
                case ({push, pop})
                    2'b10:   count_next = count_reg + CNT_W'(1);
                    2'b01:   count_next = count_reg - CNT_W'(1);
                    default: count_next = count_reg;
                endcase
            end

            // Pointers and occupancy; reset discards any buffered beats.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    count_reg <= count_next;
                end
            end

            // Storage for {tlast, slice}. There is no reset because stale
            // contents are masked by tvalid.
            always_ff @(posedge aclk) begin
                if (push) mem[wr_ptr_reg] <= {s_axis_tlast, s_axis_tdata[LSB +: W]};
            end

            // The head entry is presented directly, so a beat appears the
            // cycle after it is accepted.
            assign m_axis_tvalid[gi]          = ~empty;
            assign m_axis_tdata[gi*W +: W]    = mem[rd_ptr_reg][W-1:0];
            assign m_axis_tlast[gi]           = mem[rd_ptr_reg][W];
        end
    endgenerate

endmodule

// File: tb/tb_axis_splitter_buf.sv
// Testbench for axis_splitter_buf: directed scenarios plus random traffic,
// checked against a queue-based reference model of the slot FIFOs.
module tb_axis_splitter_buf;

    localparam int N  = 3;
    localparam int SW = 240;
    localparam int W  = 72;
    localparam int D  = 4;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [SW-1:0]    s_axis_tdata;
    logic             s_axis_tlast;
    logic [N-1:0]     s_axis_tmask;
    logic [N-1:0]     m_axis_tvalid;
    logic [N-1:0]     m_axis_tready;
    logic [N*W-1:0]   m_axis_tdata;
    logic [N-1:0]     m_axis_tlast;

    int n_cmp = 0;
    int n_err = 0;

    int          lsb [N] = '{0, 96, 168};
    logic [W:0]  q [N][$];
    logic        rst_done_m;

    always #5 aclk = ~aclk;

    axis_splitter_buf dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
`ifdef AXIS_SPLITTER_BUF_MASK_EN
        .s_axis_tmask  (s_axis_tmask),
`endif
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W:0] slot_word(input int i, input logic [SW-1:0] d, input logic l);
        logic [SW-1:0] sh;
        sh = d >> lsb[i];
        return {l, sh[W-1:0]};
    endfunction

    function automatic logic [SW-1:0] pattern(input int n);
        logic [7:0] b;
        b = 8'(n);
        return {30{b}};
    endfunction

    function automatic logic [SW-1:0] rand_data();
        logic [SW-1:0] d;
        for (int k = 0; k < 8; k++) d[k*30 +: 30] = 30'($urandom);
        return d;
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the
    // model as the DUT will advance at the next rising edge.
    task automatic step(input logic v, input logic [SW-1:0] d, input logic l,
                        input logic [N-1:0] mr, input logic [N-1:0] mk);
        logic [N-1:0] sel_m;
        logic         exp_rdy;
        logic         acc;
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        m_axis_tready = mr;
        s_axis_tmask  = mk;
`ifdef AXIS_SPLITTER_BUF_MASK_EN
        sel_m = mk;
`else
        sel_m = '1;
`endif
        @(negedge aclk);
        exp_rdy = rst_done_m;
        for (int i = 0; i < N; i++)
            if (sel_m[i] && q[i].size() >= D) exp_rdy = 1'b0;
        chk("s_tready", 128'(s_axis_tready), 128'(exp_rdy));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("m_tvalid[%0d]", i), 128'(m_axis_tvalid[i]), 128'(q[i].size() != 0));
            if (q[i].size() != 0) begin
                chk($sformatf("m_tdata[%0d]", i), 128'(m_axis_tdata[i*W +: W]), 128'(q[i][0][W-1:0]));
                chk($sformatf("m_tlast[%0d]", i), 128'(m_axis_tlast[i]), 128'(q[i][0][W]));
            end
        end
        acc = v & exp_rdy;
        for (int i = 0; i < N; i++)
            if (q[i].size() != 0 && mr[i]) void'(q[i].pop_front());
        if (acc) begin
            for (int i = 0; i < N; i++)
                if (sel_m[i]) q[i].push_back(slot_word(i, d, l));
            $display("beat t=%0t sel=%b last=%b d[7:0]=%h", $time, sel_m, l, d[7:0]);
        end
        if (aresetn) rst_done_m = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) q[i].delete();
        rst_done_m = 1'b0;
    endtask

    initial begin
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tmask  = '1;
        m_axis_tready = '1;
        clear_model();

        // Reset held: slave not ready, nothing valid.
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_tready", 128'(s_axis_tready), 128'(1'b0));
        chk("rst_tvalid", 128'(m_axis_tvalid), 128'(3'b000));
        aresetn = 1'b1;
        #1;
        chk("rel_tready_before_edge", 128'(s_axis_tready), 128'(1'b0));

        // Back-to-back beats with every lane ready.
        step(1'b0, '0, 1'b0, 3'b111, 3'b111);
        for (int n = 1; n <= 8; n++) step(1'b1, pattern(n), n == 8, 3'b111, 3'b111);
        repeat (2) step(1'b0, '0, 1'b0, 3'b111, 3'b111);

        // Slot 1 stalled: source blocks once its FIFO holds DEPTH beats.
        for (int n = 1; n <= 6; n++) step(1'b1, pattern(16 + n), 1'b0, 3'b101, 3'b111);
        step(1'b1, pattern(23), 1'b0, 3'b101, 3'b111);
        for (int n = 0; n < 8; n++) step(1'b1, pattern(24 + n), 1'b0, 3'b111, 3'b111);
        repeat (6) step(1'b0, '0, 1'b0, 3'b111, 3'b111);

        // Slot 0 full, then pop and offer a push in the same cycle.
        for (int n = 0; n < 5; n++) step(1'b1, pattern(40 + n), 1'b0, 3'b110, 3'b111);
        step(1'b1, pattern(45), 1'b1, 3'b111, 3'b111);
        step(1'b1, pattern(45), 1'b1, 3'b110, 3'b111);
        repeat (6) step(1'b0, '0, 1'b0, 3'b111, 3'b111);

        // Asynchronous reset with three beats buffered.
        for (int n = 0; n < 3; n++) step(1'b1, pattern(60 + n), 1'b0, 3'b000, 3'b111);
        s_axis_tvalid = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_rst_tvalid", 128'(m_axis_tvalid), 128'(3'b000));
        chk("async_rst_tready", 128'(s_axis_tready), 128'(1'b0));
        clear_model();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        step(1'b0, '0, 1'b0, 3'b111, 3'b111);
        repeat (2) step(1'b1, pattern(70), 1'b0, 3'b111, 3'b111);
        repeat (3) step(1'b0, '0, 1'b0, 3'b111, 3'b111);

`ifdef AXIS_SPLITTER_BUF_MASK_EN
        // Fill slot 1, then a 101-masked beat must still be accepted.
        for (int n = 0; n < 4; n++) step(1'b1, pattern(80 + n), 1'b0, 3'b101, 3'b111);
        step(1'b1, pattern(90), 1'b0, 3'b101, 3'b101);
        step(1'b1, pattern(91), 1'b0, 3'b101, 3'b000);
        step(1'b1, pattern(92), 1'b1, 3'b101, 3'b101);
        repeat (6) step(1'b0, '0, 1'b0, 3'b111, 3'b111);
`endif

        // Random traffic with random back-pressure, tlast and masks.
        for (int c = 0; c < 1500; c++) begin
            step(1'($urandom_range(0, 3) != 0), rand_data(), 1'($urandom),
                 3'($urandom), 3'($urandom));
        end
        repeat (8) step(1'b0, '0, 1'b0, 3'b111, 3'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_splitter_buf.md
# axis_splitter_buf

Parametrised, buffered AXI4-Stream broadcast splitter: one slave beat is sliced into C_NUM_MI_SLOTS fields, and each field is written into its own per-slot FIFO. Each master port drains independently, so a slow consumer stalls the source only once its own FIFO is full. The block replaces the unbuffered fixed three-way splitter in datapaths that fan one wide vector out to N processing lanes, and adds TLAST propagation.

## Interface
- C_NUM_MI_SLOTS, 3: number of master slots, 1..16.
- C_S_AXIS_TDATA_WIDTH, 240: slave TDATA width.
- C_M_AXIS_TDATA_WIDTH, 72: TDATA width of every master slot (uniform).
- C_M_AXIS_TDATA_LSB, {32'd168,32'd96,32'd0}: packed 32-bit LSB per slot, slot i at bits [32*i+:32].
  - Elaboration error if LSB+C_M_AXIS_TDATA_WIDTH > C_S_AXIS_TDATA_WIDTH for any slot.
- C_FIFO_DEPTH, 4: entries per slot FIFO. Power of two, ≥2; elaboration error otherwise.
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  1  slave beat valid.
- s_axis_tready  out  1  slave beat accepted when high with tvalid.
- s_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  slave data.
- s_axis_tlast  in  1  packet end, copied to every written slot.
- s_axis_tmask  in  C_NUM_MI_SLOTS  destination mask; present only with AXIS_SPLITTER_BUF_MASK_EN.
- m_axis_tvalid  out  C_NUM_MI_SLOTS  per-slot valid.
- m_axis_tready  in  C_NUM_MI_SLOTS  per-slot ready.
- m_axis_tdata  out  C_NUM_MI_SLOTS*C_M_AXIS_TDATA_WIDTH  slot i at [i*W+:W].
- m_axis_tlast  out  C_NUM_MI_SLOTS  per-slot last.

## Operation
- Each slot has a FIFO of {tlast, tdata slice}, with read/write pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
  - Pointers wrap modulo DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
- Selected set sel: all ones in broadcast mode, s_axis_tmask in mask mode.
- s_axis_tready = rst_done & ~|(sel & full).
  - No combinational path from m_axis_tready to s_axis_tready.
  - A full FIFO blocks the slave even in a cycle in which that FIFO is being read.
- Accept = s_axis_tvalid & s_axis_tready. On accept, every slot in sel writes s_axis_tdata[LSB_i +: W] and s_axis_tlast.
- Slot i pops when m_axis_tvalid[i] & m_axis_tready[i]. m_axis_tvalid[i] = ~empty_i.
- Simultaneous push and pop on one slot: count is unchanged and both pointers advance.
- Data and last are presented from the FIFO head. Slots with equal depth and equal ready patterns stay beat-aligned. Different ready patterns diverge by at most DEPTH beats.
- rst_done is a register cleared by reset and set on the first rising aclk after aresetn deasserts.

## Timing
- While aresetn is low, immediately and asynchronously: all pointers and counts = 0, m_axis_tvalid = 0, rst_done = 0, s_axis_tready = 0.
  - m_axis_tdata and m_axis_tlast are don't-care while tvalid = 0.
- s_axis_tready first rises one aclk edge after aresetn deasserts.
- Latency: a beat accepted at edge k shows m_axis_tvalid high after edge k; it is observable in cycle k+1.
- Throughput: one beat per cycle per slot while its FIFO is neither full nor stalled.
- Reset asserted mid-packet: all buffered beats are discarded with no partial flush. Upstream is responsible for packet recovery.

## Configuration
- AXIS_SPLITTER_BUF_MASK_EN defined:
  - s_axis_tmask port exists and each beat is written only to slots whose mask bit is 1.
  - Readiness depends only on the selected slots.
  - Mask = 0: the beat is accepted when rst_done = 1 and silently dropped.
- Not defined:
  - s_axis_tmask port is absent and every beat is broadcast to all slots.
  - Identical in behaviour to a mask of all ones.

## Test plan
- Reset release, defaults, all m_axis_tready = 1:
  - Drive beats 0x…01..0x…08 back-to-back.
  - Each slot outputs its slice one cycle after accept, 8 beats in 8 cycles.
  - s_axis_tready never drops.
- Hold m_axis_tready[1] = 0 and stream 6 beats (DEPTH = 4):
  - Slots 0 and 2 receive all beats accepted.
  - s_axis_tready drops after the 4th accept.
  - Raising tready[1] drains 4 beats in order, then accepts resume.
- Slot 0 full, then pop and push in the same cycle:
  - s_axis_tready stays 0 that cycle.
  - Count goes to 3, and the next cycle accepts.
- Assert aresetn asynchronously mid-stream with 3 beats buffered:
  - m_axis_tvalid = 0 immediately, without waiting for an edge.
  - After release, no stale beats appear and s_axis_tready returns after 1 edge.
- With AXIS_SPLITTER_BUF_MASK_EN:
  - Mask 3'b101 with slot 1 full: beat accepted, delivered to slots 0 and 2 only.
  - Mask 3'b000: beat accepted and dropped.
  - tlast=1 beat: tlast=1 on every selected slot.
